spi_i2c_bridge_ctrl: RTL and testbench
======================================

# spi_i2c_bridge_ctrl

Command sequencer between the SPI slave and the I2C master in the SPI-to-I2C bridge. It parses bytes received over SPI into I2C write or read commands and drives the I2C master's address, data, rw and enable inputs through a full handshake. It bounds each transaction with a timeout and returns a status byte or the read data to the SPI slave for shifting out on MISO.

## Interface
- TIMEOUT_CYC, 100000: max i_Clk cycles from enable assertion to transaction completion.
- i_Clk  in  1  system clock; all logic on rising edge.
- i_Rst  in  1  synchronous, active-high reset.
- i_RX_DV  in  1  one-cycle pulse, i_RX_Byte valid (from SPI slave).
- i_RX_Byte  in  8  byte received on MOSI.
- i_SPI_CS_n  in  1  SPI chip select, asynchronous to i_Clk.
- o_TX_DV  out  1  one-cycle pulse loading o_TX_Byte into the SPI slave.
- o_TX_Byte  out  8  response byte for MISO.
- o_I2C_Addr  out  7  7-bit target address.
- o_I2C_Data  out  8  write data to the I2C master.
- o_I2C_Rw  out  1  0 = write, 1 = read.
- o_I2C_Enable  out  1  transaction request to the I2C master.
- i_I2C_Ready  in  1  I2C master idle (high) / busy (low).
- i_I2C_Data  in  8  read data from the I2C master, valid when ready rises after a read.
- o_Busy  out  1  high in any state other than IDLE.
- o_Err  out  1  sticky timeout flag; cleared on the next accepted header.

## Operation
- Frame format: byte0 is the header {addr[6:0], rw}; byte1 is the data byte, present only when rw=0.
- States are IDLE, GET_DATA, LAUNCH, WAIT_DONE and RESP.
- IDLE: i_RX_DV latches the header into o_I2C_Addr/o_I2C_Rw and clears o_Err. rw=0 goes to GET_DATA; rw=1 goes to LAUNCH.
- GET_DATA: i_RX_DV latches o_I2C_Data and goes to LAUNCH. A synchronized CS_n rising edge aborts to IDLE with no I2C activity and no TX_DV.
- LAUNCH: o_I2C_Enable=1 until i_I2C_Ready is sampled low, then enable drops and the state goes to WAIT_DONE.
- WAIT_DONE: i_I2C_Ready sampled high completes the transaction and goes to RESP.
- Timeout counter: cleared on entry to LAUNCH; increments each cycle in LAUNCH and WAIT_DONE. When it reaches TIMEOUT_CYC-1 without completion: enable drops, o_Err is set and the state goes to RESP.
- RESP: one-cycle o_TX_DV, then IDLE.
  - o_TX_Byte = i_I2C_Data on a successful read.
  - o_TX_Byte = STATUS_OK (8'h01) on a successful write.
  - o_TX_Byte = STATUS_ERR (8'hE1) on any timeout.
- i_RX_DV in LAUNCH, WAIT_DONE or RESP is ignored. No queueing; the SPI host must poll by sending dummy bytes.
- CS_n deassertion during LAUNCH or WAIT_DONE does not abort, because an I2C transfer cannot be cut cleanly. The response is still produced.
- i_I2C_Ready low at LAUNCH entry (master still busy from before) is tolerated. Enable stays high, and the timeout covers a stuck master.

## Timing
- Reset values: state IDLE, o_TX_DV 0, o_TX_Byte 8'h00, o_I2C_Addr 0, o_I2C_Data 0, o_I2C_Rw 0, o_I2C_Enable 0, o_Busy 0, o_Err 0, timeout counter 0.
- Reset mid-transaction: all outputs return to reset values on the next edge, with no response pulse.
- Header RX_DV at edge N: o_I2C_Addr/Rw valid after N. For a read, o_I2C_Enable is high after N+1.
- o_I2C_Enable falls on the edge after ready is sampled low.
- o_TX_DV is high for exactly the one cycle after ready is sampled high in WAIT_DONE. o_Busy falls on the following edge.
- i_SPI_CS_n goes through a 2-flop synchronizer plus a rising-edge detect, giving 3 cycles of latency.
- Timeout counter width is $clog2(TIMEOUT_CYC); the counter saturates and never wraps.

## Structure
- Package bridge_pkg holds:
  - the state enum (IDLE, GET_DATA, LAUNCH, WAIT_DONE, RESP);
  - STATUS_OK = 8'h01 and STATUS_ERR = 8'hE1;
  - header field positions: addr = [7:1], rw = [0].
- Sub-module cs_sync: 2-flop synchronizer with rising-edge pulse output for i_SPI_CS_n.
- The FSM, timeout counter and output registers live in the top module.

## Test plan
- Write: RX 8'h54 (addr 0x2A, rw 0) then RX 8'h3C; ready model drops 2 cycles after enable and rises 20 cycles later.
  - Expect o_I2C_Addr=0x2A, o_I2C_Data=0x3C, o_I2C_Rw=0.
  - Expect one enable assertion, then o_TX_DV with o_TX_Byte=8'h01 and o_Err=0.
- Read: RX 8'h55; model returns i_I2C_Data=8'hA7.
  - Expect enable the cycle after the header with o_I2C_Rw=1.
  - Expect o_TX_Byte=8'hA7 on the o_TX_DV pulse.
- Abort: RX 8'h54, then CS_n rises before byte1.
  - Expect return to IDLE within 4 cycles.
  - Expect o_I2C_Enable never asserted and no o_TX_DV.
- Timeout: TIMEOUT_CYC=64, i_I2C_Ready stuck high after a write frame.
  - Expect enable high for 64 cycles, then low.
  - Expect o_Err=1 and o_TX_Byte=8'hE1; o_Err clears on the next header.
- Ignored bytes and reset: extra RX_DV pulses during WAIT_DONE leave the I2C outputs unchanged. i_Rst asserted in WAIT_DONE gives all outputs at reset values the next cycle, with no TX_DV.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the SPI-to-I2C bridge command sequencer.
package bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GET_DATA,
    LAUNCH,
    WAIT_DONE,
    RESP
  } state_t;

  localparam logic [7:0] STATUS_OK  = 8'h01;
  localparam logic [7:0] STATUS_ERR = 8'hE1;

  // Header byte layout: {addr[6:0], rw}
  localparam int unsigned HDR_ADDR_MSB = 7;
  localparam int unsigned HDR_ADDR_LSB = 1;
  localparam int unsigned HDR_RW_BIT   = 0;

  function automatic logic [6:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_MSB:HDR_ADDR_LSB];
  endfunction

  function automatic logic hdr_rw(input logic [7:0] hdr);
    return hdr[HDR_RW_BIT];
  endfunction

endpackage

// File: rtl/spi_i2c_bridge_ctrl_cs_sync.sv
// Two-flop synchronizer for SPI chip select with a rising-edge pulse.
module cs_sync (
  input  logic clk,
  input  logic rst,
  input  logic cs_n,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  // Resynchronize CS_n and keep one delayed copy for edge detection;
  // reset to the deasserted level so reset release never fakes an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= cs_n;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;

endmodule

// File: rtl/spi_i2c_bridge_ctrl.sv
// Command sequencer: parses SPI frames into I2C transactions, bounds each
// transaction with a timeout and returns status or read data over SPI.
module spi_i2c_bridge_ctrl
  import bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic       i_SPI_CS_n,
  output logic       o_TX_DV,
  output logic [7:0] o_TX_Byte,
  output logic [6:0] o_I2C_Addr,
  output logic [7:0] o_I2C_Data,
  output logic       o_I2C_Rw,
  output logic       o_I2C_Enable,
  input  logic       i_I2C_Ready,
  input  logic [7:0] i_I2C_Data,
  output logic       o_Busy,
  output logic       o_Err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] tmo_cnt;
  logic             cs_rise;
  logic             accept_hdr;
  logic             accept_data;
  logic             done;
  logic             timeout;

  cs_sync u_cs_sync (
    .clk  (i_Clk),
    .rst  (i_Rst),
    .cs_n (i_SPI_CS_n),
    .rise (cs_rise)
  );

  // Next-state decode and the one-cycle events that steer the registers.
  // >= rather than == on the counter: it saturates, so a non power-of-two
  // limit reached while changing state can never be stepped over.
  always_comb begin
    state_next  = state;
    accept_hdr  = 1'b0;
    accept_data = 1'b0;
    done        = 1'b0;
    timeout     = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_RX_DV) begin
          accept_hdr = 1'b1;
          state_next = hdr_rw(i_RX_Byte) ? LAUNCH : GET_DATA;
        end
      end
      GET_DATA: begin
        if (cs_rise) begin
          state_next = IDLE;
        end else if (i_RX_DV) begin
          accept_data = 1'b1;
          state_next  = LAUNCH;
        end
      end
      LAUNCH: begin
        if (tmo_cnt >= CNT_LAST) begin
          timeout    = 1'b1;
          state_next = RESP;
        end else if (!i_I2C_Ready) begin
          state_next = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (i_I2C_Ready) begin
          done       = 1'b1;
          state_next = RESP;
        end else if (tmo_cnt >= CNT_LAST) begin
          timeout    = 1'b1;
          state_next = RESP;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State, timeout counter and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state        <= IDLE;
      tmo_cnt      <= '0;
      o_TX_DV      <= 1'b0;
      o_TX_Byte    <= '0;
      o_I2C_Addr   <= '0;
      o_I2C_Data   <= '0;
      o_I2C_Rw     <= 1'b0;
      o_I2C_Enable <= 1'b0;
      o_Err        <= 1'b0;
    end else begin
      state        <= state_next;
      o_TX_DV      <= done | timeout;
      o_I2C_Enable <= (state == LAUNCH);

      if (state_next == LAUNCH && state != LAUNCH) begin
        tmo_cnt <= '0;
      end else if ((state == LAUNCH || state == WAIT_DONE) && tmo_cnt != '1) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end

      if (accept_hdr) begin
        o_I2C_Addr <= hdr_addr(i_RX_Byte);
        o_I2C_Rw   <= hdr_rw(i_RX_Byte);
        o_Err      <= 1'b0;
      end

      if (accept_data) begin
        o_I2C_Data <= i_RX_Byte;
      end

      if (timeout) begin
        o_Err     <= 1'b1;
        o_TX_Byte <= STATUS_ERR;
      end else if (done) begin
        o_TX_Byte <= o_I2C_Rw ? i_I2C_Data : STATUS_OK;
      end
    end
  end

  assign o_Busy = (state != IDLE);

endmodule

// File: tb/tb_spi_i2c_bridge_ctrl.sv
// Scoreboard bench for spi_i2c_bridge_ctrl with a small I2C master model.
module tb_spi_i2c_bridge_ctrl;

  localparam int unsigned TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_dv = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       cs_n = 1'b1;
  logic       ready = 1'b1;
  logic [7:0] i2c_rdata = '0;

  logic       tx_dv;
  logic [7:0] tx_byte;
  logic [6:0] i2c_addr;
  logic [7:0] i2c_data;
  logic       i2c_rw;
  logic       i2c_enable;
  logic       busy;
  logic       err;

  spi_i2c_bridge_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_RX_DV      (rx_dv),
    .i_RX_Byte    (rx_byte),
    .i_SPI_CS_n   (cs_n),
    .o_TX_DV      (tx_dv),
    .o_TX_Byte    (tx_byte),
    .o_I2C_Addr   (i2c_addr),
    .o_I2C_Data   (i2c_data),
    .o_I2C_Rw     (i2c_rw),
    .o_I2C_Enable (i2c_enable),
    .i_I2C_Ready  (ready),
    .i_I2C_Data   (i2c_rdata),
    .o_Busy       (busy),
    .o_Err        (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] byte_v;
    logic       err;
  } resp_t;

  resp_t exp_q[$];

  int   checks = 0;
  int   failures = 0;
  int   tx_count = 0;
  int   en_rises = 0;
  int   en_cycles = 0;
  logic en_prev = 1'b0;
  bit   stuck = 1'b0;
  logic [7:0] rd_val = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b;
    rx_dv   = 1'b1;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int bound);
    int n;
    n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tx_dv"}, {31'd0, tx_dv}, 32'd0);
    chk({tag, "_tx_byte"}, {24'd0, tx_byte}, 32'd0);
    chk({tag, "_addr"}, {25'd0, i2c_addr}, 32'd0);
    chk({tag, "_data"}, {24'd0, i2c_data}, 32'd0);
    chk({tag, "_rw"}, {31'd0, i2c_rw}, 32'd0);
    chk({tag, "_enable"}, {31'd0, i2c_enable}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  // Monitor: pop the expected response on every TX_DV pulse, track enable.
  always @(negedge clk) begin : monitor
    resp_t e;
    if (!rst) begin
      if (i2c_enable && !en_prev) en_rises++;
      if (i2c_enable) en_cycles++;
      if (tx_dv) begin
        tx_count++;
        if (exp_q.size() == 0) begin
          chk("unexpected_tx_dv", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", {24'd0, tx_byte}, {24'd0, e.byte_v});
          chk("tx_err", {31'd0, err}, {31'd0, e.err});
        end
      end
    end
    en_prev = i2c_enable;
  end

  // I2C master model: busy 2 cycles after enable, done 20 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && !stuck && i2c_enable && ready) begin
        repeat (2) @(negedge clk);
        ready = 1'b0;
        repeat (20) @(negedge clk);
        i2c_rdata = rd_val;
        ready = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int base_en;
    int base_tx;
    int n;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst = 1'b0;
    cs_n = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0x3C to 0x2A
    base_en = en_rises;
    base_tx = tx_count;
    exp_q.push_back('{8'h01, 1'b0});
    send(8'h54);
    chk("wr_addr", {25'd0, i2c_addr}, 32'h2A);
    chk("wr_rw", {31'd0, i2c_rw}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    send(8'h3C);
    chk("wr_data", {24'd0, i2c_data}, 32'h3C);
    wait_idle("write", 100);
    @(negedge clk);
    chk("wr_enable_rises", en_rises - base_en, 32'd1);
    chk("wr_tx_pulses", tx_count - base_tx, 32'd1);
    chk("wr_err", {31'd0, err}, 32'd0);

    // Read from 0x2A returning 0xA7
    rd_val = 8'hA7;
    base_tx = tx_count;
    exp_q.push_back('{8'hA7, 1'b0});
    send(8'h55);
    chk("rd_rw", {31'd0, i2c_rw}, 32'd1);
    chk("rd_addr", {25'd0, i2c_addr}, 32'h2A);
    chk("rd_enable_not_yet", {31'd0, i2c_enable}, 32'd0);
    @(negedge clk);
    chk("rd_enable_next_cycle", {31'd0, i2c_enable}, 32'd1);
    wait_idle("read", 100);
    @(negedge clk);
    chk("rd_tx_pulses", tx_count - base_tx, 32'd1);

    // Abort: CS_n rises before the data byte
    base_en = en_rises;
    base_tx = tx_count;
    send(8'h54);
    cs_n = 1'b1;
    n = 0;
    while (busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("abort_idle", {31'd0, busy}, 32'd0);
    chk("abort_within_4", {31'd0, (n <= 4)}, 32'd1);
    repeat (10) @(negedge clk);
    chk("abort_no_enable", en_rises - base_en, 32'd0);
    chk("abort_no_tx", tx_count - base_tx, 32'd0);
    cs_n = 1'b0;
    repeat (5) @(negedge clk);

    // Timeout: ready stuck high after a write frame
    stuck = 1'b1;
    base_tx = tx_count;
    exp_q.push_back('{8'hE1, 1'b1});
    send(8'h54);
    en_cycles = 0;
    send(8'h3C);
    wait_idle("timeout", 300);
    @(negedge clk);
    chk("tmo_enable_cycles", en_cycles, TMO);
    chk("tmo_enable_low", {31'd0, i2c_enable}, 32'd0);
    chk("tmo_err_sticky", {31'd0, err}, 32'd1);
    chk("tmo_tx_pulses", tx_count - base_tx, 32'd1);
    stuck = 1'b0;
    rd_val = 8'h5A;
    exp_q.push_back('{8'h5A, 1'b0});
    send(8'h55);
    chk("err_clear_on_header", {31'd0, err}, 32'd0);
    wait_idle("post_tmo_read", 100);
    @(negedge clk);

    // Ignored RX bytes in WAIT_DONE, then reset mid-transaction
    base_tx = tx_count;
    send(8'h54);
    send(8'h77);
    n = 0;
    while (ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ign_ready_dropped", {31'd0, ready}, 32'd0);
    repeat (2) @(negedge clk);
    send(8'hFF);
    send(8'h00);
    chk("ign_addr", {25'd0, i2c_addr}, 32'h2A);
    chk("ign_data", {24'd0, i2c_data}, 32'h77);
    chk("ign_rw", {31'd0, i2c_rw}, 32'd0);
    chk("ign_enable", {31'd0, i2c_enable}, 32'd0);
    chk("ign_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_no_tx", tx_count - base_tx, 32'd0);
    chk("midrst_idle", {31'd0, busy}, 32'd0);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
